// File: rtl/sched_pkg.sv
// Shared types, constants and helpers for the falling-obstacle scheduler.
package sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_MOVE,
        ST_CHECK,
        ST_OVER
    } sched_state_e;

    localparam int unsigned COORD_W       = 10;
    localparam int unsigned SCORE_W       = 10;
    localparam int unsigned STEP_W        = 3;
    localparam int unsigned SCREEN_W      = 640;
    localparam int unsigned RESPAWN_X_LIM = SCREEN_W - 32;
    localparam int unsigned RESPAWN_FOLD  = 512;
    localparam int unsigned SCORE_MAX     = 999;
    localparam int unsigned STEP_MAX      = 7;

    localparam logic [9:0] LFSR_SEED = 10'h2A5;
    // x^10 + x^7 + 1: feedback from bits 9 and 6
    localparam logic [9:0] LFSR_TAPS = 10'h240;

    localparam int unsigned INIT_X_N = 5;
    localparam int unsigned INIT_X_W = $clog2(INIT_X_N);
    localparam logic [INIT_X_N-1:0][9:0] INIT_X =
        {10'd181, 10'd535, 10'd32, 10'd510, 10'd116};

    // One Fibonacci shift of the 10-bit LFSR
    function automatic logic [9:0] lfsr_next(input logic [9:0] v);
        return {v[8:0], ^(v & LFSR_TAPS)};
    endfunction

    // Map a random value onto a legal respawn column
    function automatic logic [9:0] fold_x(input logic [9:0] v);
        return (v >= 10'(RESPAWN_X_LIM)) ? (v - 10'(RESPAWN_FOLD)) : v;
    endfunction

endpackage

// File: rtl/lfsr10.sv
// 10-bit LFSR that can step several positions in one clock.
module lfsr10
    import sched_pkg::*;
#(
    parameter int unsigned ADV_W = 3
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic [ADV_W-1:0] advance,
    output logic [9:0]       value
);

    localparam int unsigned MAX_ADV = (1 << ADV_W) - 1;

    logic [9:0] value_q;
    logic [9:0] value_d;

    // Apply 'advance' successive shifts
    always_comb begin
        value_d = value_q;
        for (int unsigned i = 0; i < MAX_ADV; i++) begin
            if (i < 32'(advance)) begin
                value_d = lfsr_next(value_d);
            end
        end
    end

    // Sequence register
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= LFSR_SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle game scheduler: moves falling obstacles each frame, respawns them,
// scores passes and sweeps one slot per cycle for player collisions.
// Optional build macro SCHED_SPEEDUP_EN raises the step every 16 points.
module obstacle_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned N_OBS     = 5,
    parameter int unsigned OBS_SIZE  = 32,
    parameter int unsigned PLAYER_W  = 32,
    parameter int unsigned PLAYER_H  = 16,
    parameter int unsigned SCREEN_H  = 480,
    parameter int unsigned BASE_STEP = 2
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 frame_tick,
    input  logic [9:0]           player_x,
    input  logic [9:0]           player_y,
    output logic [10*N_OBS-1:0]  obs_x_flat,
    output logic [10*N_OBS-1:0]  obs_y_flat,
    output logic                 gameon,
    output logic                 game_over,
    output logic [9:0]           score,
    output logic [2:0]           step,
    output logic                 busy
);

    localparam int unsigned IDX_W = (N_OBS > 1) ? $clog2(N_OBS) : 1;
    localparam int unsigned ADV_W = $clog2(N_OBS + 1);

    sched_state_e         state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [9:0]           obs_x_q [N_OBS];
    logic [9:0]           obs_x_d [N_OBS];
    logic [9:0]           obs_y_q [N_OBS];
    logic [9:0]           obs_y_d [N_OBS];
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic                 game_over_q, game_over_d;
    logic                 gameon_q, gameon_d;
    logic                 busy_q, busy_d;

    logic [9:0]           lfsr_val;
    logic [ADV_W-1:0]     lfsr_adv;
    logic [9:0]           rnd;
    logic [ADV_W-1:0]     n_resp;
    logic [10:0]          new_y;
    logic [10:0]          chk_ox, chk_oy, ply_x, ply_y;
    logic                 hit;

    function automatic logic [9:0] init_x(input int unsigned i);
        return INIT_X[INIT_X_W'(i % INIT_X_N)];
    endfunction

    function automatic logic [9:0] init_y(input int unsigned i);
        return 10'(96 * i);
    endfunction

    lfsr10 #(.ADV_W(ADV_W)) u_lfsr (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .advance  (lfsr_adv),
        .value    (lfsr_val)
    );

    // Overlap of the player with the slot currently under test (edges touching is clear)
    assign chk_ox = 11'(obs_x_q[idx_q]);
    assign chk_oy = 11'(obs_y_q[idx_q]);
    assign ply_x  = 11'(player_x);
    assign ply_y  = 11'(player_y);
    assign hit    = (ply_x < chk_ox + 11'(OBS_SIZE)) && (ply_x + 11'(PLAYER_W) > chk_ox) &&
                    (ply_y < chk_oy + 11'(OBS_SIZE)) && (ply_y + 11'(PLAYER_H) > chk_oy);

    // Next-state and datapath decisions
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        score_d     = score_q;
        step_d      = step_q;
        game_over_d = game_over_q;
        obs_x_d     = obs_x_q;
        obs_y_d     = obs_y_q;
        lfsr_adv    = ADV_W'(1);
        rnd         = lfsr_val;
        n_resp      = '0;
        new_y       = '0;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d     = ST_PLAY;
                    score_d     = '0;
                    game_over_d = 1'b0;
                    step_d      = STEP_W'(BASE_STEP);
                    for (int unsigned i = 0; i < N_OBS; i++) begin
                        obs_x_d[IDX_W'(i)] = init_x(i);
                        obs_y_d[IDX_W'(i)] = init_y(i);
                    end
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                // Respawning slots draw successive LFSR values, lowest slot first
                for (int unsigned i = 0; i < N_OBS; i++) begin
                    new_y = 11'(obs_y_q[IDX_W'(i)]) + 11'(step_q);
                    if (new_y >= 11'(SCREEN_H)) begin
                        obs_y_d[IDX_W'(i)] = '0;
                        obs_x_d[IDX_W'(i)] = fold_x(rnd);
                        rnd    = lfsr_next(rnd);
                        n_resp = n_resp + ADV_W'(1);
                        if (score_d < SCORE_W'(SCORE_MAX)) begin
                            score_d = score_d + SCORE_W'(1);
                        end
                    end else begin
                        obs_y_d[IDX_W'(i)] = new_y[9:0];
                    end
                end
`ifdef SCHED_SPEEDUP_EN
                if ((score_d[9:4] != score_q[9:4]) && (step_q < STEP_W'(STEP_MAX))) begin
                    step_d = step_q + STEP_W'(1);
                end
`endif
                if (n_resp > ADV_W'(1)) begin
                    lfsr_adv = n_resp;
                end
                idx_d   = '0;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (hit) begin
                    game_over_d = 1'b1;
                    state_d     = ST_OVER;
                end else if (idx_q == IDX_W'(N_OBS - 1)) begin
                    state_d = ST_PLAY;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        gameon_d = (state_d == ST_PLAY) || (state_d == ST_MOVE) || (state_d == ST_CHECK);
        busy_d   = (state_d == ST_MOVE) || (state_d == ST_CHECK);
    end

    // State and datapath registers
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            score_q     <= '0;
            step_q      <= STEP_W'(BASE_STEP);
            game_over_q <= 1'b0;
            gameon_q    <= 1'b0;
            busy_q      <= 1'b0;
            for (int unsigned i = 0; i < N_OBS; i++) begin
                obs_x_q[IDX_W'(i)] <= init_x(i);
                obs_y_q[IDX_W'(i)] <= init_y(i);
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            score_q     <= score_d;
            step_q      <= step_d;
            game_over_q <= game_over_d;
            gameon_q    <= gameon_d;
            busy_q      <= busy_d;
            obs_x_q     <= obs_x_d;
            obs_y_q     <= obs_y_d;
        end
    end

    for (genvar g = 0; g < N_OBS; g++) begin : g_flat
        assign obs_x_flat[10*g +: 10] = obs_x_q[g];
        assign obs_y_flat[10*g +: 10] = obs_y_q[g];
    end

    assign gameon    = gameon_q;
    assign game_over = game_over_q;
    assign score     = score_q;
    assign step      = step_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: frame-level reference model plus directed anchors.
module tb_obstacle_scheduler;

    localparam int N = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           frame_tick;
    logic [9:0]     player_x;
    logic [9:0]     player_y;
    logic [10*N-1:0] obs_x_flat;
    logic [10*N-1:0] obs_y_flat;
    logic           gameon;
    logic           game_over;
    logic [9:0]     score;
    logic [2:0]     step;
    logic           busy;

    int total = 0;
    int bad   = 0;

    int init_x_tab [5] = '{116, 510, 32, 535, 181};

    // reference model state
    int         m_x [N];
    int         m_y [N];
    int         m_score;
    int         m_step;
    int         m_on;
    int         m_over;
    int         m_sweep;   // 0: not sweeping, 1: move cycle, 2+j: checking slot j
    logic [9:0] m_lfsr;

    obstacle_scheduler dut (
        .CLOCK_50   (clk),
        .reset_n    (rst_n),
        .start      (start),
        .frame_tick (frame_tick),
        .player_x   (player_x),
        .player_y   (player_y),
        .obs_x_flat (obs_x_flat),
        .obs_y_flat (obs_y_flat),
        .gameon     (gameon),
        .game_over  (game_over),
        .score      (score),
        .step       (step),
        .busy       (busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int get_x(input int i);
        return int'(obs_x_flat[10*i +: 10]);
    endfunction

    function automatic int get_y(input int i);
        return int'(obs_y_flat[10*i +: 10]);
    endfunction

    function automatic logic [9:0] rnd_step(input logic [9:0] v);
        return {v[8:0], v[9] ^ v[6]};
    endfunction

    function automatic int fold(input logic [9:0] v);
        return (int'(v) >= 608) ? int'(v) - 512 : int'(v);
    endfunction

    function automatic bit overlaps(input int j);
        int px;
        int py;
        px = int'(player_x);
        py = int'(player_y);
        return (px < m_x[j] + 32) && (px + 32 > m_x[j]) &&
               (py < m_y[j] + 32) && (py + 16 > m_y[j]);
    endfunction

    task automatic m_place();
        for (int i = 0; i < N; i++) begin
            m_x[i] = init_x_tab[i];
            m_y[i] = 96 * i;
        end
    endtask

    task automatic m_reset();
        m_place();
        m_score = 0;
        m_step  = 2;
        m_on    = 0;
        m_over  = 0;
        m_sweep = 0;
        m_lfsr  = 10'h2A5;
    endtask

    // Reference model: advances one clock at a time from the game rules
    initial begin : model
        int adv;
        int r;
        int old;
        logic [9:0] v;
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_reset();
            end else begin
                adv = 1;
                if (m_sweep == 0) begin
                    if (m_on == 0 && start) begin
                        m_place();
                        m_score = 0;
                        m_over  = 0;
                        m_step  = 2;
                        m_on    = 1;
                    end else if (m_on == 1 && frame_tick) begin
                        m_sweep = 1;
                    end
                end else if (m_sweep == 1) begin
                    r   = 0;
                    v   = m_lfsr;
                    old = m_score;
                    for (int i = 0; i < N; i++) begin
                        if (m_y[i] + m_step >= 480) begin
                            m_y[i] = 0;
                            m_x[i] = fold(v);
                            v = rnd_step(v);
                            r++;
                            if (m_score < 999) m_score++;
                        end else begin
                            m_y[i] = m_y[i] + m_step;
                        end
                    end
`ifdef SCHED_SPEEDUP_EN
                    if ((m_score / 16 != old / 16) && m_step < 7) m_step++;
`endif
                    adv     = (r > 1) ? r : 1;
                    m_sweep = 2;
                end else begin
                    if (overlaps(m_sweep - 2)) begin
                        m_over  = 1;
                        m_on    = 0;
                        m_sweep = 0;
                    end else if (m_sweep - 2 == N - 1) begin
                        m_sweep = 0;
                    end else begin
                        m_sweep++;
                    end
                end
                for (int k = 0; k < adv; k++) m_lfsr = rnd_step(m_lfsr);
            end
        end
    end

    // Per-cycle comparison of every output against the model
    initial begin : compare
        forever begin
            @(negedge clk);
            check("gameon", int'(gameon), m_on);
            check("game_over", int'(game_over), m_over);
            check("busy", int'(busy), int'(m_sweep != 0));
            check("score", int'(score), m_score);
            check("step", int'(step), m_step);
            for (int i = 0; i < N; i++) begin
                check($sformatf("obs_x%0d", i), get_x(i), m_x[i]);
                check($sformatf("obs_y%0d", i), get_y(i), m_y[i]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(output int n);
        bit done;
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
            n++;
        end
        check("sweep_bound", int'(done), 1);
        cyc();
    endtask

    task automatic do_tick(output int n);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        wait_idle(n);
    endtask

    initial begin : stim
        int n;
        rst_n      = 1'b0;
        start      = 1'b0;
        frame_tick = 1'b0;
        player_x   = '0;
        player_y   = '0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_gameon", int'(gameon), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_over", int'(game_over), 0);
        check("rst_score", int'(score), 0);
        check("rst_step", int'(step), 2);
        for (int i = 0; i < N; i++) begin
            check("rst_y", get_y(i), 96 * i);
            check("rst_x", get_x(i), init_x_tab[i]);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;

        // start: playing on the next cycle
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        @(negedge clk);
        check("start_gameon", int'(gameon), 1);
        check("start_busy", int'(busy), 0);
        check("start_y4", get_y(4), 384);
        check("start_y1", get_y(1), 96);

        // one frame, no collision
        player_x = 10'd0;
        player_y = 10'd470;
        do_tick(n);
        check("sweep_len", n, 6);
        check("move_y4", get_y(4), 386);
        check("move_y0", get_y(0), 2);
        check("move_over", int'(game_over), 0);
        check("move_gameon", int'(gameon), 1);

        // start while playing is ignored
        start = 1'b1;
        cyc();
        start = 1'b0;
        @(negedge clk);
        check("start_ignored_y4", get_y(4), 386);

        // second tick during the check sweep is dropped
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
        cyc();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        wait_idle(n);
        repeat (3) cyc();
        @(negedge clk);
        check("drop_busy", int'(busy), 0);
        check("drop_y4", get_y(4), 388);

        // run slot 4 to the bottom and respawn
        repeat (45) do_tick(n);
        check("pre_respawn_y4", get_y(4), 478);
        check("pre_respawn_score", int'(score), 0);
        do_tick(n);
        check("respawn_y4", get_y(4), 0);
        check("respawn_score", int'(score), 1);
        check("respawn_y3", get_y(3), 384);
        check("respawn_x_range", int'(get_x(4) < 608), 1);

        // reset in the middle of a sweep
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_score", int'(score), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_gameon", int'(gameon), 0);
        check("midrst_y4", get_y(4), 384);
        cyc();
        rst_n = 1'b1;
        cyc();

        // collision with slot 0
        player_x = 10'd116;
        player_y = 10'd20;
        start    = 1'b1;
        cyc();
        start = 1'b0;
        do_tick(n);
        check("hit_sweep_len", n, 2);
        check("hit_over", int'(game_over), 1);
        check("hit_gameon", int'(gameon), 0);
        check("hit_y0", get_y(0), 2);
        repeat (3) do_tick(n);
        check("frozen_y0", get_y(0), 2);
        check("frozen_y4", get_y(4), 386);
        check("frozen_over", int'(game_over), 1);

        // restart from game over; edge touch is not a hit
        player_x = 10'd148;
        start    = 1'b1;
        cyc();
        start = 1'b0;
        @(negedge clk);
        check("restart_over", int'(game_over), 0);
        check("restart_y0", get_y(0), 0);
        do_tick(n);
        check("touch_sweep_len", n, 6);
        check("touch_over", int'(game_over), 0);
        check("touch_gameon", int'(gameon), 1);
        check("touch_y0", get_y(0), 2);

        // randomized play
        for (int c = 0; c < 8000; c++) begin
            start      = ($urandom_range(0, 49) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) begin
                if (((c / 1000) % 2) == 0) begin
                    player_x = 10'($urandom_range(610, 639));
                    player_y = 10'($urandom_range(0, 479));
                end else begin
                    player_x = 10'($urandom_range(0, 1023));
                    player_y = 10'($urandom_range(0, 1023));
                end
            end
            cyc();
        end
        start      = 1'b0;
        frame_tick = 1'b0;
        repeat (10) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 SHALL declare parameters: N_OBS, default 5, obstacle slots; OBS_SIZE, default 32, obstacle square side (px); PLAYER_W, default 32, player width; PLAYER_H, default 16, player height; SCREEN_H, default 480, respawn row; BASE_STEP, default 2, rows moved per frame.
REQ-002 SHALL have ports:
- CLOCK_50, in, 1, sole clock.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle game start/restart pulse.
- frame_tick, in, 1, one-cycle pulse per video frame.
- player_x / player_y, in, 10 each, player top-left.
- obs_x_flat / obs_y_flat, out, 10*N_OBS each, obstacle top-left; slot i at bits [10i+9:10i].
- gameon, out, 1, high in PLAY/MOVE/CHECK.
- game_over, out, 1, collision latched.
- score, out, 10, obstacles passed.
- step, out, 3, rows moved per tick.
- busy, out, 1, high in MOVE/CHECK.

Function
REQ-003 SHALL implement states IDLE, PLAY, MOVE, CHECK, OVER.
REQ-004 start in IDLE or OVER SHALL initialise the game and enter PLAY next cycle:
- score=0, game_over=0, step=BASE_STEP.
- obs_y[i]=96*i.
- obs_x = {116,510,32,535,181} for slots 0..4.
REQ-005 start in PLAY, MOVE or CHECK SHALL be ignored.
REQ-006 frame_tick in PLAY SHALL enter MOVE.
REQ-007 frame_tick in any other state SHALL be dropped, with no queuing.
REQ-008 MOVE SHALL last one cycle and update every slot in parallel: obs_y += step, computed 11-bit wide.
REQ-009 In MOVE, a slot whose 11-bit new y >= SCREEN_H SHALL respawn:
- y=0.
- x = lfsr>=608 ? lfsr-512 : lfsr.
- score+1, saturating at 999.
REQ-010 Multiple respawns in one MOVE SHALL each add 1 to score and take successive LFSR values, slot 0 first.
REQ-011 CHECK SHALL test one slot per cycle, slot 0..N_OBS-1, so frame_tick to return to PLAY is N_OBS+1 cycles.
REQ-012 Overlap SHALL use 11-bit arithmetic: px<ox+OBS_SIZE && px+PLAYER_W>ox && py<oy+OBS_SIZE && py+PLAYER_H>oy.
REQ-013 On overlap, game_over SHALL set and the state SHALL become OVER on the next cycle, with remaining slots unchecked.
REQ-014 Touching edges SHALL NOT be a collision.
REQ-015 OVER SHALL freeze all positions and score until start.
REQ-016 The LFSR SHALL be 10-bit, polynomial x^10+x^7+1, seed 10'h2A5, advancing every cycle and once per extra respawn.
REQ-017 start and frame_tick in the same cycle in IDLE/OVER: start SHALL win.

Reset
REQ-018 reset_n low SHALL asynchronously force:
- state IDLE; gameon=0, game_over=0, busy=0, score=0, step=BASE_STEP.
- REQ-004 positions.
- LFSR to seed.
REQ-019 Reset asserted mid-MOVE/CHECK SHALL abort the sweep with no partial score update.

Configuration
REQ-020 With SCHED_SPEEDUP_EN defined:
- step SHALL increment by 1 each time score crosses a multiple of 16, saturating at 7.
- the increment SHALL take effect from the next MOVE.
REQ-021 Without SCHED_SPEEDUP_EN, step SHALL remain BASE_STEP.

Structure
REQ-022 Package sched_pkg SHALL hold:
- state enum.
- SCREEN_W=640, respawn x limit 608, LFSR seed and taps.
- initial x table.
- SCORE_MAX=999, STEP_MAX=7.
REQ-023 The LFSR SHALL be sub-module lfsr10 with ports CLOCK_50, reset_n, advance, value[9:0].

Verification
REQ-024 Reset then start: next cycle gameon=1, obs_y={0,96,192,288,384}, score=0, step=2.
REQ-025 Player (0,470), frame_tick:
- MOVE: slot4 y 384->386.
- busy high 6 cycles.
- no collision; gameon stays 1.
REQ-026 Slot4 y=478, tick:
- slot4 y=0, score=1.
- x = first LFSR value folded per REQ-009.
REQ-027 Player (116,20), slot0 at (116,0), tick:
- slot0 y=2, overlap.
- game_over=1 on cycle after CHECK slot0; OVER.
- later ticks change nothing.
REQ-028 Player x=148 against slot0 x=116: edge touch, no collision.
REQ-029 SCHED_SPEEDUP_EN, score 15->16 in a MOVE: step=3 at next MOVE; repeated frame_tick during CHECK is dropped.
